// File: rtl/gray_code_pkg.sv
// Shared Gray-code definitions for the encode (counter) and decode (converter) sides.
// Functions operate on GRAY_N_MAX-bit values; narrower counts are zero-extended.
package gray_code_pkg;

   localparam int unsigned GRAY_N_MIN = 2;
   localparam int unsigned GRAY_N_MAX = 16;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   function automatic logic [GRAY_N_MAX-1:0] bin2gray(input logic [GRAY_N_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GRAY_N_MAX-1:0] gray2bin(input logic [GRAY_N_MAX-1:0] g);
      logic [GRAY_N_MAX-1:0] b;
      b[GRAY_N_MAX-1] = g[GRAY_N_MAX-1];
      for (int unsigned k = 0; k < GRAY_N_MAX-1; k++) begin
         b[GRAY_N_MAX-2-k] = b[GRAY_N_MAX-1-k] ^ g[GRAY_N_MAX-2-k];
      end
      return b;
   endfunction

   function automatic int unsigned popcount(input logic [GRAY_N_MAX-1:0] v);
      int unsigned c;
      c = 0;
      for (int unsigned k = 0; k < GRAY_N_MAX; k++) begin
         c += int'(v[k]);
      end
      return c;
   endfunction

endpackage

// File: rtl/binary_to_gray_encoder.sv
// Combinational N-bit binary-to-Gray encoder on the counter's next-count path.
module binary_to_gray_encoder #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] bin,
   output logic [N-1:0] gray
);

   always_comb begin
      gray = bin ^ (bin >> 1);
   end

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down binary counter with registered Gray output and wrap pulse.
// Define GRAY_STEP_CHECK_EN to add the sticky step_err single-bit-change checker.
module gray_code_counter
   import gray_code_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   input  logic         up_dn,
   input  logic         load,
   input  logic [N-1:0] load_value,
   output logic [N-1:0] gray_value,
   output logic [N-1:0] binary_value,
   output logic         wrap
`ifdef GRAY_STEP_CHECK_EN
   ,
   output logic         step_err
`endif
);

   if (N < GRAY_N_MIN || N > GRAY_N_MAX) begin : g_bad_n
      $error("gray_code_counter: N out of range");
   end

   logic [N-1:0] cnt;
   logic [N-1:0] cnt_next;
   logic [N-1:0] gray_next;
   logic         wrap_next;
   logic         stepping;
   dir_e         dir;

   assign dir          = dir_e'(up_dn);
   assign binary_value = cnt;

   always_comb begin
      cnt_next  = cnt;
      wrap_next = 1'b0;
      stepping  = 1'b0;
      if (load) begin
         cnt_next = load_value;
      end else if (en) begin
         stepping = 1'b1;
         if (dir == DIR_UP) begin
            cnt_next  = cnt + 1'b1;
            wrap_next = (cnt == '1);
         end else begin
            cnt_next  = cnt - 1'b1;
            wrap_next = (cnt == '0);
         end
      end
   end

   binary_to_gray_encoder #(.N(N)) u_enc (
      .bin  (cnt_next),
      .gray (gray_next)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt        <= '0;
         gray_value <= '0;
         wrap       <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         gray_value <= gray_next;
         wrap       <= wrap_next;
      end
   end

`ifdef GRAY_STEP_CHECK_EN
   // prev_gray is rebuilt from the package encoder, independent of u_enc.
   logic [N-1:0]            prev_gray;
   logic [GRAY_N_MAX-1:0]   next_ext;
   logic [GRAY_N_MAX-1:0]   prev_ext;
   logic [GRAY_N_MAX-1:0]   chk_gray;

   always_comb begin
      next_ext              = '0;
      next_ext[N-1:0]       = cnt_next;
      prev_ext              = '0;
      prev_ext[N-1:0]       = prev_gray;
      chk_gray              = bin2gray(next_ext);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prev_gray <= '0;
         step_err  <= 1'b0;
      end else begin
         prev_gray <= chk_gray[N-1:0];
         if (stepping && (popcount(prev_ext ^ chk_gray) != 1)) begin
            step_err <= 1'b1;
         end
      end
   end
`else
   logic unused_stepping;
   assign unused_stepping = stepping;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed self-checking bench for gray_code_counter (N=4).
module tb_gray_code_counter;

   logic       clk;
   logic       rstn;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_value;
   logic [3:0] gray_value;
   logic [3:0] binary_value;
   logic       wrap;
`ifdef GRAY_STEP_CHECK_EN
   logic       step_err;
`endif

   int checks;
   int failures;

   logic [3:0] up_seq [0:16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

   gray_code_counter #(.N(4)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .en           (en),
      .up_dn        (up_dn),
      .load         (load),
      .load_value   (load_value),
      .gray_value   (gray_value),
      .binary_value (binary_value),
      .wrap         (wrap)
`ifdef GRAY_STEP_CHECK_EN
      ,
      .step_err     (step_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs at negedge, then sample 1 ns after the following posedge.
   task automatic cycle(input logic l, input logic [3:0] lv, input logic e, input logic u);
      @(negedge clk);
      load = l; load_value = lv; en = e; up_dn = u;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b0; load_value = 4'h0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1; load_value = 4'h7;
      #3;
      checks++;
      if ({binary_value, gray_value, wrap} !== 9'h0) begin
         failures++;
         $display("FAIL reset_async: bin=%h gray=%h wrap=%b required 0/0/0", binary_value, gray_value, wrap);
      end
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if ({binary_value, gray_value, wrap} !== 9'h0) begin
         failures++;
         $display("FAIL reset_hold: bin=%h gray=%h wrap=%b required 0/0/0", binary_value, gray_value, wrap);
      end
      en = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_up_sweep();
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b0, 4'h0, 1'b1, 1'b1);
         checks++;
         if (gray_value !== up_seq[i] || wrap !== (i == 16)) begin
            failures++;
            $display("FAIL up_sweep[%0d]: gray=%h wrap=%b required gray=%h wrap=%b",
                     i, gray_value, wrap, up_seq[i], (i == 16));
         end
      end
   endtask

   task automatic test_down_wrap();
      do_reset();
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (binary_value !== 4'hF || gray_value !== 4'h8 || wrap !== 1'b1) begin
         failures++;
         $display("FAIL down_wrap: bin=%h gray=%h wrap=%b required F/8/1", binary_value, gray_value, wrap);
      end
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (binary_value !== 4'hE || gray_value !== 4'h9 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL down_step: bin=%h gray=%h wrap=%b required E/9/0", binary_value, gray_value, wrap);
      end
   endtask

   task automatic test_load();
      cycle(1'b1, 4'h5, 1'b1, 1'b0);
      checks++;
      if (binary_value !== 4'h5 || gray_value !== 4'h7 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL load_over_en: bin=%h gray=%h wrap=%b required 5/7/0", binary_value, gray_value, wrap);
      end
      cycle(1'b0, 4'h0, 1'b1, 1'b1);
      checks++;
      if (binary_value !== 4'h6 || gray_value !== 4'h5 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL step_after_load: bin=%h gray=%h wrap=%b required 6/5/0", binary_value, gray_value, wrap);
      end
      cycle(1'b1, 4'hF, 1'b0, 1'b0);
      cycle(1'b1, 4'h3, 1'b1, 1'b1);
      checks++;
      if (binary_value !== 4'h3 || gray_value !== 4'h2 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL load_no_wrap: bin=%h gray=%h wrap=%b required 3/2/0", binary_value, gray_value, wrap);
      end
   endtask

   task automatic test_hold();
      cycle(1'b1, 4'h9, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 4'h2, 1'b0, i[0]);
         checks++;
         if (binary_value !== 4'h9 || gray_value !== 4'hD || wrap !== 1'b0) begin
            failures++;
            $display("FAIL hold[%0d]: bin=%h gray=%h wrap=%b required 9/D/0", i, binary_value, gray_value, wrap);
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 4'hB, 1'b0, 1'b1);
      @(negedge clk);
      load = 1'b0; en = 1'b1;
      #1 rstn = 1'b0;
      #1;
      checks++;
      if ({binary_value, gray_value, wrap} !== 9'h0) begin
         failures++;
         $display("FAIL reset_mid: bin=%h gray=%h wrap=%b required 0/0/0", binary_value, gray_value, wrap);
      end
      @(negedge clk);
      rstn = 1'b1;
      cycle(1'b1, 4'hF, 1'b0, 1'b1);
      cycle(1'b0, 4'h0, 1'b1, 1'b1);
      checks++;
      if (wrap !== 1'b1 || binary_value !== 4'h0) begin
         failures++;
         $display("FAIL wrap_before_reset: bin=%h wrap=%b required 0/1", binary_value, wrap);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (wrap !== 1'b0) begin
         failures++;
         $display("FAIL reset_clears_wrap: wrap=%b required 0", wrap);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (binary_value !== 4'h1 || gray_value !== 4'h1 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL resume_after_reset: bin=%h gray=%h wrap=%b required 1/1/0", binary_value, gray_value, wrap);
      end
   endtask

   task automatic test_random_mix();
      logic [3:0] m;
      logic       mw;
      logic       l, e, u;
      logic [3:0] lv;
      m = binary_value;
      for (int i = 0; i < 64; i++) begin
         l  = ($urandom_range(0, 7) == 0);
         e  = ($urandom_range(0, 3) != 0);
         u  = 1'($urandom_range(0, 1));
         lv = 4'($urandom_range(0, 15));
         mw = 1'b0;
         if (l) m = lv;
         else if (e && u) begin mw = (m == 4'hF); m = m + 4'h1; end
         else if (e) begin mw = (m == 4'h0); m = m - 4'h1; end
         cycle(l, lv, e, u);
         checks++;
         if (binary_value !== m || gray_value !== (m ^ (m >> 1)) || wrap !== mw) begin
            failures++;
            $display("FAIL random[%0d]: bin=%h gray=%h wrap=%b required %h/%h/%b",
                     i, binary_value, gray_value, wrap, m, m ^ (m >> 1), mw);
         end
`ifdef GRAY_STEP_CHECK_EN
         checks++;
         if (step_err !== 1'b0) begin
            failures++;
            $display("FAIL step_err[%0d]: step_err=%b required 0", i, step_err);
         end
`endif
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_up_sweep();
      test_down_wrap();
      test_load();
      test_hold();
      test_reset_mid();
      test_random_mix();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
